muldiv_seq: RTL and testbench

Iterative 16-bit multiply/divide sequencer serving the accumulator datapath. The main controller issues one MUL or DIV operation with a one-cycle `start` and holds its state until `done`. The block then runs a WIDTH-step shift-add multiply or restoring divide on ACC and MDR operands, and returns quotient, product and remainder in registers.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_seq.sv | 116 +++++++++++
 tb/tb_muldiv_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] operand,
  input  logic             bit_in,
  output logic [WIDTH-1:0] acc_out,
  output logic             q_bit
);

  // Shifted partial remainder needs one extra bit before the trial subtract
  logic [WIDTH:0] shifted;

  // MUL adds the shifted multiplicand when the multiplier LSB is set; DIV
  // subtracts the divisor and restores when the trial would go negative
  always_comb begin
    acc_out = '0;
    q_bit   = 1'b0;
    shifted = {acc_in, bit_in};
    if (op == OP_MUL) begin
      acc_out = acc_in + (bit_in ? operand : '0);
    end else if (shifted >= {1'b0, operand}) begin
      acc_out = shifted[WIDTH-1:0] - operand;
      q_bit   = 1'b1;
    end else begin
      acc_out = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 16-bit multiply/divide sequencer: one start, WIDTH steps, one done.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic             op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] step_acc;
  logic             q_bit;
  logic             bit_in;
  logic             zero_div;

  assign zero_div = (op == OP_DIV) && (b == '0);
  assign bit_in   = (op_q == OP_MUL) ? shreg[0] : shreg[WIDTH-1];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc_in  (acc),
    .operand (opnd),
    .bit_in  (bit_in),
    .acc_out (step_acc),
    .q_bit   (q_bit)
  );

  // Next-state decode; a zero divisor skips iteration entirely
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = zero_div ? DONE : RUN;
      RUN:     if (count == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
    end
  end

  // Operand latch, per-step datapath update and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      op_q        <= OP_MUL;
      acc         <= '0;
      opnd        <= '0;
      shreg       <= '0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q        <= op;
            acc         <= '0;
            opnd        <= b;
            shreg       <= a;
            count       <= CW'(WIDTH - 1);
            div_by_zero <= zero_div;
            if (zero_div) begin
              result    <= '1;
              remainder <= a;
            end
          end
        end
        RUN: begin
          acc <= step_acc;
          if (op_q == OP_MUL) begin
            opnd  <= opnd << 1;
            shreg <= shreg >> 1;
          end else begin
            shreg <= {shreg[WIDTH-2:0], q_bit};
          end
          if (count == '0) begin
            result    <= (op_q == OP_MUL) ? step_acc : {shreg[WIDTH-2:0], q_bit};
            remainder <= (op_q == OP_MUL) ? '0 : step_acc;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         dbz;

  int checkCount = 0;
  int passCount  = 0;

  // Free-running clock
  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (dbz)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic void refModel(input logic opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    logic [31:0] prod;
    prod = 32'(aIn) * 32'(bIn);
    z = 1'b0;
    if (opIn == OP_MUL) begin
      q = prod[W-1:0];
      r = '0;
    end else if (bIn == '0) begin
      q = '1;
      r = aIn;
      z = 1'b1;
    end else begin
      q = aIn / bIn;
      r = aIn % bIn;
    end
  endfunction

  task automatic applyStimulus(input logic opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn);
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  task automatic runOp(input logic opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                       input int pulseA, input int pulseB, input int abortCycle);
    logic [W-1:0] expQ, expR, prevResult;
    logic         expZ, overlap, stable;
    int           doneCycle, busyCycles;
    refModel(opIn, aIn, bIn, expQ, expR, expZ);
    prevResult = result;
    applyStimulus(opIn, aIn, bIn);
    doneCycle  = 0;
    busyCycles = 0;
    overlap    = 1'b0;
    stable     = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c == abortCycle) begin
        rst = 1'b0;
        #1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort result", result, 0);
        checkOutput("abort remainder", remainder, 0);
        checkOutput("abort dbz", dbz, 0);
        repeat (3) begin
          @(posedge clk);
          #1;
          if (done) doneCycle = c;
        end
        checkOutput("abort no done", doneCycle, 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (busy) busyCycles++;
      if (busy && done) overlap = 1'b1;
      if (!done && result !== prevResult) stable = 1'b0;
      start = (c == pulseA) || (c == pulseB);
      if (start) begin
        op = 1'($urandom);
        a  = 16'($urandom);
        b  = 16'($urandom);
      end
      if (done) begin
        doneCycle = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("done cycle", doneCycle, expZ ? 1 : W + 1);
    checkOutput("busy cycles", busyCycles, expZ ? 0 : W);
    checkOutput("busy/done overlap", overlap, 0);
    checkOutput("result stable", stable, 1);
    checkOutput("result", result, expQ);
    checkOutput("remainder", remainder, expR);
    checkOutput("div_by_zero", dbz, expZ);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done one cycle", done, 0);
    checkOutput("result hold", result, expQ);
  endtask

  // Directed cases first, then randomized operations
  initial begin
    logic         opR;
    logic [W-1:0] aR, bR;
    rst   = 1'b0;
    start = 1'b0;
    op    = OP_MUL;
    a     = '0;
    b     = '0;
    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b1;

    runOp(OP_MUL, 16'd7, 16'd9, 0, 0, 0);
    runOp(OP_MUL, 16'h0100, 16'h0100, 0, 0, 0);
    runOp(OP_DIV, 16'd100, 16'd7, 0, 0, 0);
    runOp(OP_DIV, 16'hFFFF, 16'd1, 0, 0, 0);
    runOp(OP_DIV, 16'd5, 16'd0, 0, 0, 0);
    runOp(OP_MUL, 16'd6, 16'd7, 0, 0, 0);
    runOp(OP_MUL, 16'd3, 16'd4, 5, 17, 0);
    runOp(OP_MUL, 16'd11, 16'd13, 0, 0, 0);
    runOp(OP_DIV, 16'd1000, 16'd3, 0, 0, 8);
    runOp(OP_DIV, 16'd1000, 16'd3, 0, 0, 0);

    repeat (10) begin
      opR = 1'($urandom);
      aR  = 16'($urandom);
      bR  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      runOp(opR, aR, bR, 0, 0, 0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
